// File: rtl/rect_target_scheduler.sv
// Collects detector boxes during the active frame, keeps the two largest valid ones,
// and commits them to the overlay buses at end of frame, holding stale boxes for HOLD_FRAMES commits.
module rect_target_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_FRAMES = 3,
  parameter int IMG_HDISP   = 1280,
  parameter int IMG_VDISP   = 720
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   per_frame_vsync,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [43*NUM_REQ-1:0]  req_box,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [42:0]            target_pos_out1,
  output logic [42:0]            target_pos_out2,
  output logic                   frame_update,
  output logic [15:0]            drop_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_BLANK   = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  localparam logic [PTR_W:0]   NREQ     = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [3:0]       HOLD_LIM = 4'(HOLD_FRAMES - 1);
  localparam logic [11:0]      H_LIM    = 12'(IMG_HDISP);
  localparam logic [10:0]      V_LIM    = 11'(IMG_VDISP);

  logic [1:0]       state;
  logic             vsync_d;
  logic             rise_pend;
  logic [PTR_W-1:0] rr_ptr;
  logic             sh_full1, sh_full2;
  logic [41:0]      sh_box1, sh_box2;
  logic [20:0]      sh_area1, sh_area2;
  logic [3:0]       age1, age2;

  logic             rise, fall;
  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W:0]   cand;
  logic [PTR_W-1:0] next_ptr;

  assign rise = ~vsync_d &  per_frame_vsync;
  assign fall =  vsync_d & ~per_frame_vsync;

  // Round-robin search starting at rr_ptr; grants only while collecting an active frame.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    if (state == ST_COLLECT && per_frame_vsync && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (cand >= NREQ) cand = cand - NREQ;
        if (!grant_any && req_valid[cand[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[PTR_W-1:0];
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_any && (grant_idx == PTR_W'(i));
    end
  end

  assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);

  logic        xfer;
  logic [42:0] in_box;
  logic [10:0] in_xmin, in_xmax;
  logic [9:0]  in_ymin, in_ymax;
  logic [10:0] box_w;
  logic [9:0]  box_h;
  logic [20:0] area;
  logic        box_ok;
  logic        repl1, bigger;
  logic        wr_slot1, wr_slot2, drop_inc;

  assign xfer    = grant_any;
  assign in_box  = req_box[int'(grant_idx)*43 +: 43];
  assign in_ymax = in_box[41:32];
  assign in_xmax = in_box[31:21];
  assign in_ymin = in_box[20:11];
  assign in_xmin = in_box[10:0];

  assign box_ok = in_box[42] && (in_xmin <= in_xmax) && (in_ymin <= in_ymax) &&
                  ({1'b0, in_xmax} < H_LIM) && ({1'b0, in_ymax} < V_LIM);

  assign box_w = in_xmax - in_xmin + 11'd1;
  assign box_h = in_ymax - in_ymin + 10'd1;
  assign area  = 21'(box_w) * 21'(box_h);

  // On a tie the second slot is the one displaced.
  assign repl1  = sh_area1 < sh_area2;
  assign bigger = area > (repl1 ? sh_area1 : sh_area2);

  assign wr_slot1 = xfer && box_ok && (!sh_full1 || (sh_full2 && bigger && repl1));
  assign wr_slot2 = xfer && box_ok && sh_full1 && (!sh_full2 || (bigger && !repl1));
  // With both slots full a transfer always costs one box: either the newcomer or a displaced one.
  assign drop_inc = xfer && (!box_ok || (sh_full1 && sh_full2));

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state           <= ST_BLANK;
      vsync_d         <= 1'b1;  // a frame already in progress at reset must not look like a rise
      rise_pend       <= 1'b0;
      rr_ptr          <= '0;
      sh_full1        <= 1'b0;
      sh_full2        <= 1'b0;
      age1            <= '0;
      age2            <= '0;
      target_pos_out1 <= '0;
      target_pos_out2 <= '0;
      frame_update    <= 1'b0;
      drop_cnt        <= '0;
    end else begin
      vsync_d      <= per_frame_vsync;
      frame_update <= 1'b0;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      case (state)
        ST_BLANK: begin
          rise_pend <= 1'b0;
          if (rise || (rise_pend && per_frame_vsync)) state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (xfer) rr_ptr <= next_ptr;
          if (wr_slot1) sh_full1 <= 1'b1;
          if (wr_slot2) sh_full2 <= 1'b1;
          if (fall) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (sh_full1) begin
            target_pos_out1 <= {1'b1, sh_box1};
            age1            <= '0;
          end else if (target_pos_out1[42] && age1 < HOLD_LIM) begin
            age1 <= age1 + 4'd1;
          end else begin
            target_pos_out1 <= '0;
            age1            <= '0;
          end

          if (sh_full2) begin
            target_pos_out2 <= {1'b1, sh_box2};
            age2            <= '0;
          end else if (target_pos_out2[42] && age2 < HOLD_LIM) begin
            age2 <= age2 + 4'd1;
          end else begin
            target_pos_out2 <= '0;
            age2            <= '0;
          end

          sh_full1     <= 1'b0;
          sh_full2     <= 1'b0;
          frame_update <= 1'b1;
          rise_pend    <= rise;
          state        <= ST_BLANK;
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

  // NOTE: slot payloads carry no reset; they are only ever read while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (wr_slot1) begin
      sh_box1  <= in_box[41:0];
      sh_area1 <= area;
    end
    if (wr_slot2) begin
      sh_box2  <= in_box[41:0];
      sh_area2 <= area;
    end
  end

endmodule

// File: tb/tb_rect_target_scheduler.sv
// Bench for rect_target_scheduler: table-driven box sequences plus hand-written frame/reset corners,
// with commits checked from a scoreboard queue when frame_update fires.
module tb_rect_target_scheduler;
  localparam int NUM_REQ = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  vsync;
  logic [NUM_REQ-1:0]    req_valid;
  logic [43*NUM_REQ-1:0] req_box;
  logic [NUM_REQ-1:0]    req_ready;
  logic [42:0]           out1, out2;
  logic                  frame_update;
  logic [15:0]           drop_cnt;

  rect_target_scheduler #(
    .NUM_REQ(NUM_REQ), .HOLD_FRAMES(3), .IMG_HDISP(1280), .IMG_VDISP(720)
  ) dut (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync),
    .req_valid(req_valid), .req_box(req_box), .req_ready(req_ready),
    .target_pos_out1(out1), .target_pos_out2(out2),
    .frame_update(frame_update), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] mk(input logic f, input int ymax, input int xmax,
                                     input int ymin, input int xmin);
    return {f, 10'(ymax), 11'(xmax), 10'(ymin), 11'(xmin)};
  endfunction

  typedef struct {
    logic [42:0] e1;
    logic [42:0] e2;
    int          at;
  } commit_t;
  commit_t sb[$];

  always @(negedge clk) begin
    commit_t c;
    if (frame_update) begin
      if (sb.size() == 0) begin
        check("unexpected_frame_update", 1, 0);
      end else begin
        c = sb.pop_front();
        check("frame_update_cycle", 64'(cyc), 64'(c.at));
        check("commit_out1", out1, c.e1);
        check("commit_out2", out2, c.e2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic open_frame();
    vsync = 1'b1;
    tick();
  endtask

  task automatic send(input int ch, input logic [42:0] box, input logic inc, input string nm);
    logic [NUM_REQ-1:0] onehot;
    onehot = '0;
    onehot[ch] = 1'b1;
    req_valid = onehot;
    req_box = '0;
    req_box[ch*43 +: 43] = box;
    #1;
    check({nm, "_ready"}, req_ready, onehot);
    tick();
    req_valid = '0;
    if (inc) exp_drop++;
    check({nm, "_drop"}, drop_cnt, exp_drop);
  endtask

  task automatic close_frame(input logic [42:0] e1, input logic [42:0] e2);
    commit_t c;
    vsync = 1'b0;
    #1;
    check("fall_ready", req_ready, 0);
    c.e1 = e1; c.e2 = e2; c.at = cyc + 2;
    sb.push_back(c);
    repeat (4) tick();
  endtask

  typedef struct {
    int          ch;
    logic [42:0] box;
    logic        inc;
    logic        first;
    logic        last;
    logic [42:0] e1;
    logic [42:0] e2;
  } vec_t;
  vec_t vt[11];

  logic [42:0] b0, ba, bb, bc, bd, be, bf, bg;
  logic [NUM_REQ-1:0] exp_rr;
  commit_t cm;

  initial begin
    b0 = mk(1, 100, 200, 50, 20);
    ba = mk(1, 9, 9, 0, 0);              // area 100
    bb = mk(1, 219, 119, 200, 100);      // area 400
    bc = mk(1, 329, 529, 300, 500);      // area 900
    bd = mk(1, 609, 1039, 600, 1000);    // area 400, ties the smaller slot
    be = mk(1, 719, 1279, 319, 1279);    // area 401 at the image corner
    bf = mk(1, 9, 9, 0, 0);              // area 100
    bg = mk(1, 59, 59, 50, 50);          // area 100
    // frame X: keep the two largest, tie with smaller slot is dropped
    vt[0]  = '{0, ba, 1'b0, 1'b1, 1'b0, 43'd0, 43'd0};
    vt[1]  = '{1, bb, 1'b0, 1'b0, 1'b0, 43'd0, 43'd0};
    vt[2]  = '{2, bc, 1'b1, 1'b0, 1'b0, 43'd0, 43'd0};
    vt[3]  = '{3, bd, 1'b1, 1'b0, 1'b1, bc, bb};
    // frame Y: only invalid boxes, committed boxes are held
    vt[4]  = '{0, mk(0, 100, 200, 50, 20),  1'b1, 1'b1, 1'b0, 43'd0, 43'd0};
    vt[5]  = '{1, mk(1, 100, 200, 50, 300), 1'b1, 1'b0, 1'b0, 43'd0, 43'd0};
    vt[6]  = '{2, mk(1, 100, 1280, 50, 20), 1'b1, 1'b0, 1'b0, 43'd0, 43'd0};
    vt[7]  = '{3, mk(1, 720, 200, 50, 20),  1'b1, 1'b0, 1'b1, bc, bb};
    // frame Z: equal slot areas, larger box displaces slot 2
    vt[8]  = '{1, bf, 1'b0, 1'b1, 1'b0, 43'd0, 43'd0};
    vt[9]  = '{2, bg, 1'b0, 1'b0, 1'b0, 43'd0, 43'd0};
    vt[10] = '{3, be, 1'b1, 1'b0, 1'b1, bf, be};

    rst = 1'b1; vsync = 1'b0; req_valid = '0; req_box = '0;
    tick();
    tick();
    check("rst_ready", req_ready, 0);
    check("rst_out1", out1, 0);
    check("rst_out2", out2, 0);
    check("rst_frame_update", frame_update, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();

    // Empty frames: outputs stay zero, one pulse per frame.
    repeat (4) begin
      open_frame();
      repeat (3) begin
        #1 check("idle_ready", req_ready, 0);
        tick();
      end
      close_frame(43'd0, 43'd0);
    end
    check("empty_drop", drop_cnt, 0);

    // One box, then aging out after three commits.
    open_frame();
    send(0, b0, 1'b0, "hold_src");
    close_frame(b0, 43'd0);
    for (int f = 0; f < 3; f++) begin
      open_frame();
      tick();
      check("hold_mid_frame_out1", out1, b0);
      close_frame((f < 2) ? b0 : 43'd0, 43'd0);
    end

    // Round-robin with all requesters valid (flag=0 boxes, so each is a drop).
    do_reset();
    exp_drop = 0;
    open_frame();
    req_box = '0;
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      exp_rr = '0;
      exp_rr[i % NUM_REQ] = 1'b1;
      #1 check("rr_grant", req_ready, exp_rr);
      tick();
    end
    exp_drop += 5;
    close_frame(43'd0, 43'd0);
    #1 check("blank_ready", req_ready, 0);
    req_valid = '0;
    check("rr_drop", drop_cnt, exp_drop);

    for (int i = 0; i < $size(vt); i++) begin
      if (vt[i].first) open_frame();
      send(vt[i].ch, vt[i].box, vt[i].inc, $sformatf("tbl%0d", i));
      if (vt[i].last) close_frame(vt[i].e1, vt[i].e2);
    end

    // Reset mid-frame with vsync held high: no grants until a real rise, no commit at the fall.
    open_frame();
    send(0, b0, 1'b0, "mid_rst_pre");
    req_valid = 4'b0001;
    rst = 1'b1;
    #1 check("mid_rst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    exp_drop = 0;
    repeat (4) begin
      #1 check("post_rst_ready", req_ready, 0);
      tick();
    end
    vsync = 1'b0;
    req_valid = '0;
    repeat (4) tick();
    check("post_rst_out1", out1, 0);
    check("post_rst_drop", drop_cnt, 0);

    // Real rise collects again; next rise lands in the COMMIT cycle.
    open_frame();
    send(1, b0, 1'b0, "post_rst_box");
    vsync = 1'b0;
    #1;
    cm.e1 = b0; cm.e2 = 43'd0; cm.at = cyc + 2;
    sb.push_back(cm);
    tick();
    vsync = 1'b1;
    tick();
    req_box = '0;
    req_valid = 4'b0100;
    #1 check("commit_rise_blank_ready", req_ready, 0);
    tick();
    #1 check("commit_rise_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    exp_drop++;
    check("commit_rise_drop", drop_cnt, exp_drop);
    close_frame(b0, 43'd0);

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_target_scheduler.md
Name: rect_target_scheduler

Overview:
- Collects candidate bounding boxes from NUM_REQ detector channels during the active frame.
- Arbitrates them round-robin and keeps the two largest valid boxes in shadow slots.
- At the end of each frame it commits the shadow slots to the two 43-bit box buses that drive the rectangle-overlay stage.
- Boxes that are not refreshed are held for HOLD_FRAMES frames and then cleared, so the overlay does not flicker.

Parameters:
- NUM_REQ, 4, number of detector requesters (2..8).
- HOLD_FRAMES, 3, frames a committed box survives without a refresh (1..15).
- IMG_HDISP, 1280, active pixels per line; xmax must be less than this.
- IMG_VDISP, 720, active lines; ymax must be less than this.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- per_frame_vsync  in  1  high during the active frame, low during blanking.
- req_valid  in  NUM_REQ  per-requester box valid.
- req_box  in  43*NUM_REQ  requester i occupies bits [43i+42:43i], packed {flag[42], ymax[41:32], xmax[31:21], ymin[20:11], xmin[10:0]}.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- target_pos_out1  out  43  committed slot 1, same packing.
- target_pos_out2  out  43  committed slot 2, same packing.
- frame_update  out  1  one-cycle pulse when the outputs change to a new commit.
- drop_cnt  out  16  saturating count of rejected or displaced-out boxes.

Behaviour:
- Interface: one clock domain (clk). rst is synchronous and active-high.
- Reset: state=BLANK, rr_ptr=0, shadow slots empty, ages=0, target_pos_out1/2=0, frame_update=0, drop_cnt=0, req_ready=0.
- vsync_d is per_frame_vsync registered once. Rise = ~vsync_d & vsync. Fall = vsync_d & ~vsync.
- State BLANK:
  - req_ready=0.
  - On rise, go to COLLECT.
  - After reset, a mid-frame vsync=1 is ignored until a real rise, so a partial frame is never collected.
- State COLLECT:
  - Round-robin arbiter: search from rr_ptr for the lowest-index-after-pointer requester with req_valid=1.
  - req_ready is combinational and one-hot to that requester, only while per_frame_vsync=1.
  - After a transfer, rr_ptr = granted index + 1, mod NUM_REQ. At most one transfer per cycle.
  - On fall, go to COMMIT. req_ready=0 in the fall cycle.
- Box validation: box is valid iff flag=1, xmin<=xmax, ymin<=ymax, xmax<IMG_HDISP, ymax<IMG_VDISP. An invalid box is still consumed (ready high) and increments drop_cnt.
- Area = (xmax-xmin+1)*(ymax-ymin+1), computed unsigned at 21 bits.
- Insertion of a valid box, in priority order:
  - If slot1 is empty, place it in slot1.
  - Else if slot2 is empty, place it in slot2.
  - Else if its area is strictly greater than the smaller slot area, replace that slot and increment drop_cnt (displaced box). Equal slot areas: replace slot2.
  - Otherwise drop it and increment drop_cnt.
- State COMMIT (exactly 1 cycle). For each slot k:
  - Shadow full: out_k = shadow box with flag=1, age_k=0.
  - Else out_k.flag=1 and age_k < HOLD_FRAMES-1: hold out_k, age_k += 1.
  - Else: out_k = 43'd0, age_k=0.
  - Then clear the shadow slots and assert frame_update on the cycle after COMMIT, coincident with the new output values. Go to BLANK.
- Latency: fall at cycle t → COMMIT at t+1 → outputs and frame_update valid at t+2. Outputs are constant throughout the following active frame.
- drop_cnt saturates at 16'hFFFF.
- Rise and fall cannot occur in the same cycle. A rise while in COMMIT is taken from BLANK on the next cycle (vsync level is re-checked: if vsync=1 and vsync_d=1 in BLANK after COMMIT, go straight to COLLECT).
- rst asserted in any state returns to the reset values on the next edge. Requesters that were mid-handshake see req_ready=0.

Test Plan:
- Reset then a frame with no requests, repeated for 4 frames → outputs stay 0, frame_update pulses once per frame at fall+2, drop_cnt=0.
- Req0 box {1,100,200,50,20} in frame 1, nothing afterwards → out1 equals that box at fall+2, holds for 3 commits total (HOLD_FRAMES=3), reads 0 after the 4th commit.
- Req0 through req3 all valid continuously → grants 0,1,2,3,0 in consecutive cycles, one-hot, with no grant during vsync low.
- Three valid boxes with areas 100, 400, 900 → commit out1=900-box, out2=400-box (slot1 replaced smaller after ordering check), drop_cnt=1. Also check that a box with area equal to the smaller slot is dropped.
- Invalid boxes (flag=0; xmin=300 > xmax=200; xmax=1280) → each consumed in 1 cycle, drop_cnt +3, outputs unchanged.
- rst pulsed mid-frame with vsync held high → req_ready stays 0 until the next vsync rise, and no commit happens at the intervening fall.
